// File: rtl/tube_pkg.sv
// Shared defaults and helpers for the Tube data register FIFO.
package tube_pkg;

  localparam int   DW_DEF    = 8;
  localparam int   DEPTH_DEF = 24;
  localparam logic STB_IDLE  = 1'b1;

  // Count width needed to hold 0..depth inclusive.
  function automatic int cw_for(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tube_strobe_edge.sv
// Rising-edge detector for an active-low bus strobe; history idles high so reset never fakes an event.
module tube_strobe_edge
  import tube_pkg::*;
(
  input  logic clk,
  input  logic r,
  input  logic stb_n,
  output logic evt
);

  logic prev_r;

  // Strobe history register, reset to the idle level.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      prev_r <= STB_IDLE;
    end else begin
      prev_r <= stb_n;
    end
  end

  assign evt = ~prev_r & stb_n;

endmodule

// File: rtl/tube_reg_fifo.sv
// Byte FIFO for one Tube data register channel with edge-detected push/pop strobes.
// Optional macro TUBE_FIFO_IRQ_EN adds irq_en/irq (registered irq_en && data_avail).
module tube_reg_fifo
  import tube_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = cw_for(DEPTH)
) (
  input  logic          clk,
  input  logic          r,
  input  logic          clr,
  input  logic          wr_stb_n,
  input  logic [DW-1:0] wdata,
  input  logic          rd_stb_n,
`ifdef TUBE_FIFO_IRQ_EN
  input  logic          irq_en,
  output logic          irq,
`endif
  output logic [DW-1:0] rdata,
  output logic          data_avail,
  output logic          not_full,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [CW-1:0] wr_ptr_r, rd_ptr_r, count_r;
  logic [DW-1:0] wdata_r, rdata_r;
  logic          data_avail_r, not_full_r, ovf_r;
  logic          wr_evt_s, rd_evt_s, do_push_s, do_pop_s, empty_s, full_s;
  logic [CW-1:0] rd_nxt_s, wr_nxt_s, count_nxt_s;
  logic [DW-1:0] head_nxt_s;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    if (p == LAST) begin
      return ZERO;
    end else begin
      return p + ONE;
    end
  endfunction

  tube_strobe_edge u_wr_edge (.clk(clk), .r(r), .stb_n(wr_stb_n), .evt(wr_evt_s));
  tube_strobe_edge u_rd_edge (.clk(clk), .r(r), .stb_n(rd_stb_n), .evt(rd_evt_s));

  // Push/pop qualification, next count and next head byte.
  always_comb begin
    empty_s   = (count_r == ZERO);
    full_s    = (count_r == FULL);
    do_pop_s  = rd_evt_s & ~empty_s;
    do_push_s = wr_evt_s & (~full_s | do_pop_s);
    rd_nxt_s  = ptr_inc(rd_ptr_r);
    wr_nxt_s  = ptr_inc(wr_ptr_r);
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + ONE;
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - ONE;
    end else begin
      count_nxt_s = count_r;
    end
    // New head may be the byte being written this very cycle.
    if (do_push_s && (rd_nxt_s == wr_ptr_r)) begin
      head_nxt_s = wdata_r;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Write data holding register, tracks wdata while the writer strobe is low.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      wdata_r <= {DW{1'b0}};
    end else if (!wr_stb_n) begin
      wdata_r <= wdata;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr) begin
      mem_r[wr_ptr_r] <= wdata_r;
    end
  end

  // Pointers, count, flags and registered head byte.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      wr_ptr_r     <= ZERO;
      rd_ptr_r     <= ZERO;
      count_r      <= ZERO;
      data_avail_r <= 1'b0;
      not_full_r   <= 1'b1;
      ovf_r        <= 1'b0;
      rdata_r      <= {DW{1'b0}};
    end else if (clr) begin
      wr_ptr_r     <= ZERO;
      rd_ptr_r     <= ZERO;
      count_r      <= ZERO;
      data_avail_r <= 1'b0;
      not_full_r   <= 1'b1;
      ovf_r        <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_nxt_s;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      count_r      <= count_nxt_s;
      data_avail_r <= (count_nxt_s != ZERO);
      not_full_r   <= (count_nxt_s != FULL);
      if (wr_evt_s && full_s && !do_pop_s) begin
        ovf_r <= 1'b1;
      end
      if (do_pop_s && (count_nxt_s != ZERO)) begin
        rdata_r <= head_nxt_s;
      end else if (do_push_s && empty_s) begin
        rdata_r <= wdata_r;
      end
    end
  end

`ifdef TUBE_FIFO_IRQ_EN
  logic irq_r;

  // Interrupt follows data_avail by one cycle when enabled.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      irq_r <= 1'b0;
    end else if (clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en & data_avail_r;
    end
  end

  assign irq = irq_r;
`endif

  assign rdata      = rdata_r;
  assign data_avail = data_avail_r;
  assign not_full   = not_full_r;
  assign count      = count_r;
  assign ovf        = ovf_r;

endmodule

// File: doc/tube_reg_fifo.md
Name: tube_reg_fifo

Overview:
Byte FIFO for one Tube data register channel: the writing CPU pushes bytes, the reading CPU pops them. It sits directly upstream of the host-side status flag stage. It produces the data-available and not-full conditions, plus the head byte, that the flag stage registers and presents to the bus. Bus strobes are edge-detected in the single clock domain. Push/pop takes effect at the end of each bus cycle.

Parameters:
DEPTH, 24, number of byte entries (any value 2..255; need not be a power of two)
DW, 8, data width
CW, 5, count width; must hold DEPTH

Ports:
clk  in  1  system clock; all state changes on rising edge
r  in  1  asynchronous active-high reset
clr  in  1  synchronous flush, active-high
wr_stb_n  in  1  writer bus strobe, active-low; push on its rising edge
wdata  in  DW  write data, sampled in the cycle wr_stb_n is seen low
rd_stb_n  in  1  reader bus strobe, active-low; pop on its rising edge
rdata  out  DW  head-of-queue byte, registered (first-word-fall-through)
data_avail  out  1  queue non-empty
not_full  out  1  queue has a free entry
count  out  CW  entries held, 0..DEPTH
ovf  out  1  sticky: push attempted while full

Behaviour:
- Reset (r=1, async): pointers=0, count=0, data_avail=0, not_full=1, ovf=0, rdata=0x00, strobe history regs=1 (idle). Memory is not reset.
- Strobe edge: prev<=strobe each cycle; event = prev==0 && strobe==1. A strobe held low across reset release and then raised counts as one event.
- wdata capture: a wdata holding reg loads every cycle wr_stb_n==0; the push writes the last value captured while the strobe was low.
- Latency: edge detected in cycle N; mem, pointers, count and flags update at the rising edge ending N; all outputs are valid in N+1.
- rdata: registered copy of mem[rd_ptr]. Reloads after every push-into-empty and every pop. Holds the last value while empty.
- Push on full: data dropped, pointers unchanged, ovf<=1.
- Pop on empty: ignored, no flag change.
- Simultaneous push+pop, non-empty and non-full: both occur, count unchanged.
- Simultaneous push+pop, full: both occur; count stays DEPTH; ovf not set.
- Simultaneous push+pop, empty: push accepted, pop ignored, count=1.
- Pointer wrap: DEPTH-1 -> 0 explicitly; no power-of-two masking.
- data_avail = (count!=0), not_full = (count!=DEPTH); both registered, updated with count.
- clr: pointers, count and ovf cleared; data_avail=0, not_full=1. It overrides any same-cycle push/pop, and those events are discarded. Strobe history regs still update.
- Reset mid-transfer: any in-flight strobe edge is lost and the queue is emptied.

Optional Feature:
- Macro TUBE_FIFO_IRQ_EN.
- Defined: adds input irq_en (1) and output irq (1). irq is registered, = irq_en && data_avail, so it asserts one cycle after data_avail. Reset value 0. clr forces 0 next cycle.
- Undefined: both ports and the logic are absent.

Decomposition:
- Package tube_pkg: DW default (8), DEPTH default (24), a function returning CW for a given DEPTH, and a localparam for the strobe idle level (1).
- Sub-module tube_strobe_edge: async-reset synchronous rising-edge detector with history reset to 1. Instantiated once each for wr_stb_n and rd_stb_n.

Test Plan:
- Reset, then idle -> count=0, data_avail=0, not_full=1, ovf=0, rdata=0x00.
- One write pulse with wdata=0xA5 -> the cycle after the rising edge: count=1, data_avail=1, rdata=0xA5; one read pulse -> count=0, data_avail=0, rdata holds 0xA5.
- 24 writes of 0x00..0x17, then a 25th of 0xFF -> not_full=0 after the 24th, ovf=1 after the 25th, count=24. Then 24 reads return 0x00..0x17 in order; 0xFF is never seen.
- Fill 20, drain 20, repeat 3x with incrementing data -> pointers wrap past 23; every byte is read back in order; data_avail toggles correctly.
- Write and read edges in the same cycle: at count=5 -> count stays 5; at count=24 -> count stays 24, ovf stays 0; at count=0 -> count=1, rdata equals the written byte.
- clr pulse coinciding with a write edge at count=7, then async r asserted mid-strobe -> after clr count=0, ovf=0, write discarded; after r all outputs are at reset values. With TUBE_FIFO_IRQ_EN and irq_en=1, irq rises one cycle after data_avail and falls after the queue drains.
